// File: rtl/ring_uart_tx.sv
// Pops bytes from an external ring buffer and serializes them as 8N1-style UART frames.
// Every output is registered: each is computed from the next state and loaded on the same edge as the state.
module ring_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int ACK_TIMEOUT  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  txEnable,
    input  logic [31:0]           bufferLength,
    output logic                  readEnable,
    input  logic                  dataReadAck,
    input  logic [DATA_WIDTH-1:0] dataRead,
    output logic                  txOut,
    output logic                  busy,
    output logic [31:0]           bytesSent,
    output logic [2:0]            o_dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [15:0]      CLK_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

    logic [2:0]            r_state;
    logic [15:0]           r_clk_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [TO_W-1:0]       r_to_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [31:0]           r_bytes;
    logic                  r_read_en;
    logic                  r_tx;
    logic                  r_busy;

    logic [2:0]            w_state_next;
    logic [15:0]           w_clk_next;
    logic [BIT_W-1:0]      w_bit_next;
    logic [TO_W-1:0]       w_to_next;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [31:0]           w_bytes_next;
    logic                  w_tx_next;

    // Read handshake: readEnable is a one-cycle pop request; the buffer answers with
    // dataReadAck (dataRead valid) during WAIT. Acks seen in any other state are ignored.
    always_comb begin
        w_state_next = r_state;
        w_clk_next   = r_clk_cnt;
        w_bit_next   = r_bit_cnt;
        w_to_next    = r_to_cnt;
        w_shift_next = r_shift;
        w_bytes_next = r_bytes;
        case (r_state)
            S_IDLE: begin
                if (txEnable && (bufferLength != 32'd0)) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                w_state_next = S_WAIT;
                w_to_next    = '0;
            end
            S_WAIT: begin
                if (dataReadAck) begin
                    w_shift_next = dataRead;
                    w_clk_next   = '0;
                    w_state_next = S_START;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_to_next = r_to_cnt + TO_W'(1);
                end
            end
            S_START: begin
                if (r_clk_cnt == CLK_LAST) begin
                    w_clk_next   = '0;
                    w_bit_next   = '0;
                    w_state_next = S_DATA;
                end else begin
                    w_clk_next = r_clk_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (r_clk_cnt == CLK_LAST) begin
                    w_clk_next   = '0;
                    w_shift_next = r_shift >> 1;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_next = r_bit_cnt + BIT_W'(1);
                    end
                end else begin
                    w_clk_next = r_clk_cnt + 16'd1;
                end
            end
            S_STOP: begin
                if (r_clk_cnt == CLK_LAST) begin
                    w_clk_next   = '0;
                    w_bytes_next = r_bytes + 32'd1;
                    w_state_next = S_IDLE;
                end else begin
                    w_clk_next = r_clk_cnt + 16'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // The line level for the coming cycle: the shift register LSB is the current data bit.
    always_comb begin
        w_tx_next = 1'b1;
        if (w_state_next == S_START) begin
            w_tx_next = 1'b0;
        end else if (w_state_next == S_DATA) begin
            w_tx_next = w_shift_next[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
            r_shift   <= '0;
            r_bytes   <= '0;
            r_read_en <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_clk_cnt <= w_clk_next;
            r_bit_cnt <= w_bit_next;
            r_to_cnt  <= w_to_next;
            r_shift   <= w_shift_next;
            r_bytes   <= w_bytes_next;
            r_read_en <= (w_state_next == S_REQ);
            r_tx      <= w_tx_next;
            r_busy    <= (w_state_next != S_IDLE);
        end
    end

    assign readEnable  = r_read_en;
    assign txOut       = r_tx;
    assign busy        = r_busy;
    assign bytesSent   = r_bytes;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ring_uart_tx.sv
// Bench for ring_uart_tx: a ring-buffer responder drives the DUT, every cycle of the outputs is
// recorded, and frames are rebuilt from expected bytes as start/data/stop bit windows.
module tb_ring_uart_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
    localparam int ATO = 4;
    localparam int FL  = (DW + 2) * CPB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          txEnable = 1'b0;
    logic [31:0]   bufferLength = 32'd0;
    logic          dataReadAck = 1'b0;
    logic [DW-1:0] dataRead = '0;
    logic          readEnable;
    logic          txOut;
    logic          busy;
    logic [31:0]   bytesSent;
    logic [2:0]    dbg_state;

    ring_uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB),
        .ACK_TIMEOUT (ATO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .txEnable    (txEnable),
        .bufferLength(bufferLength),
        .readEnable  (readEnable),
        .dataReadAck (dataReadAck),
        .dataRead    (dataRead),
        .txOut       (txOut),
        .busy        (busy),
        .bytesSent   (bytesSent),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_sent = 0;

    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    logic          tx_q[$];
    logic          re_q[$];
    logic          busy_q[$];

    bit ack_on   = 1'b1;
    bit noise_on = 1'b0;
    bit pend_ack = 1'b0;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: sample outputs, then act as the ring buffer for the coming edge.
    task automatic tick();
        logic [DW-1:0] b;
        @(negedge clk);
        tx_q.push_back(txOut);
        re_q.push_back(readEnable);
        busy_q.push_back(busy);
        dataReadAck = 1'b0;
        if (pend_ack) begin
            pend_ack = 1'b0;
            if (ack_on && src_q.size() > 0) begin
                b = src_q.pop_front();
                dataReadAck = 1'b1;
                dataRead = b;
                exp_q.push_back(b);
            end
        end else if (noise_on) begin
            dataReadAck = 1'($urandom_range(0, 1));
            dataRead = DW'($urandom);
        end
        if (readEnable === 1'b1) pend_ack = 1'b1;
        bufferLength = 32'(src_q.size());
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_start(input string tag, input int bound, output int idx);
        bit found = 1'b0;
        idx = -1;
        for (int i = 0; i < bound && !found; i++) begin
            tick();
            if (txOut === 1'b0) begin
                found = 1'b1;
                idx = tx_q.size() - 1;
            end
        end
        chk({tag, "_start_seen"}, 64'(found), 64'd1);
    endtask

    function automatic int count_val(input logic q[$], input int from, input logic v);
        int c = 0;
        for (int i = from; i < q.size(); i++) if (q[i] === v) c++;
        return c;
    endfunction

    function automatic int find_val(input logic q[$], input int from, input logic v);
        for (int i = from; i < q.size(); i++) if (q[i] === v) return i;
        return -1;
    endfunction

    // Rebuild each frame found on the line and compare with the next expected byte.
    task automatic check_frames(input string tag, input int first, input int n_exp, input bit chk_gap);
        int i = first;
        int prev_end = -1;
        int nfr = 0;
        int bn;
        logic [FL-1:0] obs;
        logic [FL-1:0] expv;
        logic [DW-1:0] b;
        while (i < tx_q.size()) begin
            if (tx_q[i] === 1'b0) begin
                for (int k = 0; k < FL; k++) obs[k] = (i + k < tx_q.size()) ? tx_q[i + k] : 1'bx;
                b = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                for (int k = 0; k < FL; k++) begin
                    bn = k / CPB;
                    expv[k] = (bn == 0) ? 1'b0 : ((bn <= DW) ? b[bn - 1] : 1'b1);
                end
                chk({tag, "_frame"}, 64'(obs), 64'(expv));
                if (chk_gap && prev_end >= 0) chk({tag, "_gap"}, 64'(i - prev_end - 1), 64'd3);
                prev_end = i + FL - 1;
                i = i + FL;
                nfr++;
            end else begin
                i++;
            end
        end
        chk({tag, "_frame_count"}, 64'(nfr), 64'(n_exp));
    endtask

    initial begin
        int first;
        int s;
        int r;
        int k;
        int reqs[$];

        // Reset state
        run(3);
        chk("rst_txOut", 64'(txOut), 64'd1);
        chk("rst_readEnable", 64'(readEnable), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_bytesSent", 64'(bytesSent), 64'd0);
        reset = 1'b0;
        txEnable = 1'b1;

        // Empty buffer, spurious acks in IDLE: nothing happens
        noise_on = 1'b1;
        first = tx_q.size();
        run(50);
        noise_on = 1'b0;
        run(2);
        chk("empty_readEnable_cycles", 64'(count_val(re_q, first, 1'b1)), 64'd0);
        chk("empty_txOut_low_cycles", 64'(count_val(tx_q, first, 1'b0)), 64'd0);
        chk("empty_busy_cycles", 64'(count_val(busy_q, first, 1'b1)), 64'd0);
        chk("empty_bytesSent", 64'(bytesSent), 64'd0);

        // Single 'hA5 frame, ack in the first WAIT cycle
        src_q.push_back(8'hA5);
        first = tx_q.size();
        run(60);
        r = find_val(re_q, first, 1'b1);
        s = find_val(tx_q, first, 1'b0);
        chk("a5_req_to_start", 64'(s - r), 64'd2);
        chk("a5_req_cycles", 64'(count_val(re_q, first, 1'b1)), 64'd1);
        check_frames("a5", first, 1, 1'b0);
        exp_sent = 1;
        chk("a5_bytesSent", 64'(bytesSent), 64'(exp_sent));
        chk("a5_idle_busy", 64'(busy), 64'd0);

        // Three back-to-back frames
        src_q.push_back(8'h01);
        src_q.push_back(8'h02);
        src_q.push_back(8'h03);
        first = tx_q.size();
        run(3 * (FL + 3) + 20);
        check_frames("b2b", first, 3, 1'b1);
        exp_sent += 3;
        chk("b2b_bytesSent", 64'(bytesSent), 64'(exp_sent));

        // Random bursts
        for (int round = 0; round < 4; round++) begin
            k = $urandom_range(1, 4);
            for (int j = 0; j < k; j++) src_q.push_back(DW'($urandom));
            first = tx_q.size();
            run(k * (FL + 3) + 20);
            check_frames("rand", first, k, 1'b1);
            exp_sent += k;
            chk("rand_bytesSent", 64'(bytesSent), 64'(exp_sent));
        end

        // No ack: REQ, 4 WAIT cycles, IDLE, then REQ again
        ack_on = 1'b0;
        src_q.push_back(DW'($urandom));
        first = tx_q.size();
        run(20);
        for (int i = first; i < re_q.size(); i++) if (re_q[i] === 1'b1) reqs.push_back(i);
        chk("to_req_seen", 64'(reqs.size() >= 3), 64'd1);
        if (reqs.size() >= 3) begin
            chk("to_req_period_1", 64'(reqs[1] - reqs[0]), 64'd6);
            chk("to_req_period_2", 64'(reqs[2] - reqs[1]), 64'd6);
            chk("to_busy_last_wait", 64'(busy_q[reqs[0] + 4]), 64'd1);
            chk("to_busy_idle", 64'(busy_q[reqs[0] + 5]), 64'd0);
        end
        chk("to_txOut_low_cycles", 64'(count_val(tx_q, first, 1'b0)), 64'd0);
        chk("to_bytesSent", 64'(bytesSent), 64'(exp_sent));
        txEnable = 1'b0;
        src_q.delete();
        run(10);
        ack_on = 1'b1;
        txEnable = 1'b1;

        // txEnable dropped during the START bit of the first of two frames
        src_q.push_back(DW'($urandom));
        src_q.push_back(DW'($urandom));
        first = tx_q.size();
        wait_start("en", 20, s);
        txEnable = 1'b0;
        run(60);
        check_frames("en_first", first, 1, 1'b0);
        exp_sent += 1;
        chk("en_bytesSent", 64'(bytesSent), 64'(exp_sent));
        chk("en_no_second_req", 64'(count_val(re_q, s, 1'b1)), 64'd0);
        chk("en_idle_busy", 64'(busy), 64'd0);
        txEnable = 1'b1;
        first = tx_q.size();
        run(60);
        check_frames("en_second", first, 1, 1'b0);
        exp_sent += 1;
        chk("en_bytesSent_2", 64'(bytesSent), 64'(exp_sent));

        // Reset during DATA bit 3 of 'hFF
        src_q.push_back(8'hFF);
        first = tx_q.size();
        wait_start("rst", 20, s);
        run(4 * CPB + 1);
        reset = 1'b1;
        tick();
        chk("midrst_txOut", 64'(txOut), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_readEnable", 64'(readEnable), 64'd0);
        chk("midrst_bytesSent", 64'(bytesSent), 64'd0);
        reset = 1'b0;
        exp_q.delete();
        first = tx_q.size();
        run(50);
        chk("midrst_no_resume", 64'(count_val(tx_q, first, 1'b0)), 64'd0);
        chk("midrst_bytesSent_after", 64'(bytesSent), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_uart_tx.md
RING_UART_TX -- requirements
Module: ring_uart_tx

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of each byte popped from the ring buffer and serialized.
REQ-002 Parameter: CLKS_PER_BIT, default 4, clk cycles per serial bit; legal range 2..65535.
REQ-003 Parameter: ACK_TIMEOUT, default 4, maximum WAIT cycles for dataReadAck before the read is abandoned.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port: clk  input  1  rising-edge clock.
REQ-006 Port: reset  input  1  synchronous, active-high reset.
REQ-007 Port: txEnable  input  1  permits starting a new frame.
REQ-008 Port: bufferLength  input  32  ring buffer occupancy.
REQ-009 Port: readEnable  output  1  pop request to the ring buffer.
REQ-010 Port: dataReadAck  input  1  ring buffer read-success flag.
REQ-011 Port: dataRead  input  DATA_WIDTH  popped byte, valid when dataReadAck=1.
REQ-012 Port: txOut  output  1  serial line, idle high.
REQ-013 Port: busy  output  1  high in every state except IDLE.
REQ-014 Port: bytesSent  output  32  count of completed frames.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, WAIT, START, DATA, STOP; all outputs SHALL be registered.
REQ-016 IDLE: if txEnable=1 and bufferLength!=0, go to REQ next cycle; otherwise stay.
REQ-017 REQ: assert readEnable=1 for exactly this one cycle, then go to WAIT; readEnable SHALL be 0 in every other state.
REQ-018 WAIT: on the first cycle with dataReadAck=1, capture dataRead into the shift register and go to START.
REQ-019 WAIT: if no dataReadAck within ACK_TIMEOUT cycles, return to IDLE; no frame sent and bytesSent unchanged.
REQ-020 dataReadAck outside WAIT SHALL be ignored.
REQ-021 START: txOut=0 for CLKS_PER_BIT cycles.
REQ-022 DATA: send DATA_WIDTH bits LSB first, each held CLKS_PER_BIT cycles.
REQ-023 STOP: txOut=1 for CLKS_PER_BIT cycles, increment bytesSent on the last STOP cycle, then go to IDLE.
REQ-024 txOut SHALL be 1 in IDLE, REQ and WAIT.
REQ-025 Frame length SHALL be (DATA_WIDTH+2)*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle.
REQ-026 Minimum gap between the last STOP cycle and the next START cycle SHALL be 3 cycles (IDLE, REQ, WAIT with immediate ack).
REQ-027 Deasserting txEnable mid-frame SHALL NOT abort the frame; it only blocks the next IDLE->REQ transition.
REQ-028 bytesSent SHALL wrap from 2^32-1 to 0.
REQ-029 A bufferLength change during a frame SHALL have no effect until IDLE.

Reset
REQ-030 With reset=1 at a clock edge, the next state SHALL be IDLE.
REQ-031 On that edge: txOut=1, readEnable=0, busy=0, bytesSent=0, and bit/cycle/timeout counters cleared.
REQ-032 Reset asserted mid-frame SHALL discard the captured byte without completing it; txOut returns high on that edge.
REQ-033 Reset SHALL take priority over all other inputs.

Verification
REQ-034 Reset, txEnable=1, bufferLength=0 for 50 cycles -> readEnable stays 0, txOut stays 1, busy=0.
REQ-035 bufferLength=1, ack with dataRead='hA5 one cycle after REQ -> txOut = 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 total); then bytesSent=1.
REQ-036 bufferLength=3, ack every read with 'h01, 'h02, 'h03 -> three frames, each gap exactly 3 cycles; bytesSent=3.
REQ-037 bufferLength=1, dataReadAck never asserted -> 4 WAIT cycles, then IDLE; txOut=1 throughout, bytesSent=0; with bufferLength still 1, REQ repeats.
REQ-038 Reset pulsed during DATA bit 3 of 'hFF -> next edge txOut=1, busy=0, bytesSent=0; no STOP emitted.
REQ-039 txEnable dropped during the START bit of frame 1 with bufferLength=2 -> frame 1 completes, bytesSent=1, no second REQ until txEnable=1.
